fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Shares the single write port of a shared buffer FIFO among NUM_REQ independent producers.
- Round-robin fairness, with optional burst lock: a granted producer keeps the port for up to MAX_BURST consecutive beats.
- Sits directly in front of the FIFO write interface and honours its full flag, so no write is ever dropped.
- The grant decision is combinational from registered state, so the accept latency is zero cycles.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 8, width of each requester's data word; must equal the FIFO data width.
- MAX_BURST, 4, maximum consecutive beats per ownership (>=1; 1 gives pure per-beat round-robin).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester write request; data is valid while high.
- req_data  in  NUM_REQ*DATA_WIDTH  flattened data; slice i belongs to requester i.
- ack  out  NUM_REQ  one-hot; ack[i] high means requester i's word is written this cycle.
- fifo_wr  out  1  FIFO write strobe.
- fifo_data  out  DATA_WIDTH  FIFO write data, equal to the winner's slice.
- fifo_full  in  1  FIFO full flag.
- owner  out  $clog2(NUM_REQ)  index of the locked owner; 0 when idle.
- busy  out  1  high while in state OWN.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, beat_cnt=0, owner=0, busy=0. ack and fifo_wr are 0 during reset regardless of req.
- States:
  - IDLE: no owner.
  - OWN: owner locked, beat_cnt holds the beats used in the current ownership.
- Winner selection, each cycle:
  - In OWN with req[owner]=1 and beat_cnt<MAX_BURST: winner is owner.
  - Otherwise: winner is the first asserted req scanning rr_ptr, rr_ptr+1, ..., modulo NUM_REQ.
  - No req asserted: no winner.
- Grant: if a winner exists and fifo_full=0, then:
  - ack[winner]=1, fifo_wr=1, fifo_data=req_data[winner].
  - All other ack bits are 0.
- Full stall: fifo_full=1 forces ack=0 and fifo_wr=0. State, owner, beat_cnt and rr_ptr all hold; ownership is kept across the stall.
- Transitions on a grant:
  - New acquisition (winner differs from owner, or state was IDLE, or beat_cnt==MAX_BURST): owner<=winner, beat_cnt<=1, rr_ptr<=winner+1 (wrap), state<=OWN.
  - Continuation: beat_cnt<=beat_cnt+1.
  - When MAX_BURST==1, every grant is a new acquisition.
- Release to IDLE with beat_cnt<=0 happens when:
  - in OWN, req[owner]=0 and no other req is asserted (no grant); or
  - in OWN with no grant and beat_cnt==MAX_BURST.
- Work-conserving:
  - When an exhausted or dropped owner releases, a different requester can win in the same cycle.
  - An exhausted owner wins again only if it is the sole requester; it then starts a fresh burst with beat_cnt=1.
- Requester contract:
  - req must stay high with stable data until ack.
  - Deasserting req without ack is legal; the word is withdrawn.
- beat_cnt width is $clog2(MAX_BURST+1) and it never exceeds MAX_BURST.
- Reset mid-burst returns everything to reset values on the next edge; no ack is issued in the reset cycle.

Optional Feature:
- Macro FIFO_ARB_STATS_EN.
- Defined:
  - Adds output gnt_cnt, NUM_REQ*16 bits: a per-requester count of acked beats, saturating at 16'hFFFF, cleared by rst.
  - Adds input stats_clr, 1 bit: synchronously clears all counters. If stats_clr and an ack occur in the same cycle, the count ends at 0.
- Undefined: no counters and no extra ports. Arbitration behaviour is identical in both builds.

Decomposition:
- Package fifo_arb_pkg:
  - state enum arb_state_t {IDLE, OWN}.
  - Constant STAT_W=16.
  - Function for index width, $clog2 with a minimum of 1.
- Sub-module rr_pick: combinational rotating-priority encoder.
  - Inputs: req vector and start pointer.
  - Outputs: found and index.
  - Instanced once; the top level holds the state machine, counters and data mux.

Test Plan (NUM_REQ=4, MAX_BURST=4):
- Reset, then req=4'b0101 held, fifo_full=0 -> acks: req0 x4 beats, req2 x4, req0 x4 ...; busy=1 throughout; owner toggles 0/2.
- req=4'b1111 for 16 cycles, MAX_BURST=1 build -> ack order 0,1,2,3,0,1,2,3...; rr_ptr wraps 3->0.
- req0 granted 2 beats, fifo_full=1 for 3 cycles -> ack=0 and fifo_wr=0 for those cycles. On release, req0 gets beats 3 and 4 before req1 (req1 asserted throughout).
- req0 owner drops req after beat 2 while req3 is asserted -> req3 acked in the same cycle, owner=3, beat_cnt=1.
- req1 sole requester for 10 cycles -> acked every cycle; beat_cnt sequence 1,2,3,4,1,2,...
- Stats build: 5 acks to req2, then stats_clr with a simultaneous ack -> gnt_cnt[2]=0; rst mid-burst -> ack=0 and all counters 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} arb_state_t;

  localparam int STAT_W = 16;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set bit of req at or after start, modulo N.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    int c;
    logic [IW-1:0] ci;
    c = 0;
    ci = '0;
    found = 1'b0;
    idx = '0;
    // Walk from farthest offset to nearest so the nearest hit wins.
    for (int i = N - 1; i >= 0; i--) begin
      c = (int'(start) + i) % N;
      ci = IW'(c);
      if (req[ci]) begin
        found = 1'b1;
        idx = ci;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter with burst lock in front of a shared FIFO write port.
// Optional per-requester grant counters are built when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  input  logic                          fifo_full,
  output logic [idx_w(NUM_REQ)-1:0]     owner,
  output logic                          busy
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic                          stats_clr,
  output logic [NUM_REQ*STAT_W-1:0]     gnt_cnt
`endif
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] MAX_B = BW'(MAX_BURST);

  arb_state_t     state;
  logic [BW-1:0]  beat_cnt;
  logic [IW-1:0]  rr_ptr;

  logic           pick_found;
  logic [IW-1:0]  pick_idx;
  logic           cont;
  logic           win_vld;
  logic [IW-1:0]  win;
  logic           grant;
  logic           new_acq;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req   (req),
    .start (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    cont    = (state == OWN) && req[owner] && (beat_cnt < MAX_B);
    win     = cont ? owner : pick_idx;
    win_vld = cont || pick_found;
    grant   = win_vld && !fifo_full && !rst;
    new_acq = (state == IDLE) || (win != owner) || (beat_cnt == MAX_B);
  end

  always_comb begin
    ack = '0;
    fifo_data = '0;
    if (grant) ack[win] = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant && (win == IW'(i))) fifo_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign fifo_wr = grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      beat_cnt <= '0;
      rr_ptr   <= '0;
      busy     <= 1'b0;
    end else if (grant) begin
      if (new_acq) begin
        state    <= OWN;
        busy     <= 1'b1;
        owner    <= win;
        beat_cnt <= BW'(1);
        rr_ptr   <= (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end else if (!fifo_full && (state == OWN)) begin
      // Nothing requesting at all: give up ownership.
      state    <= IDLE;
      busy     <= 1'b0;
      owner    <= '0;
      beat_cnt <= '0;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] cnt_q [NUM_REQ];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst || stats_clr) cnt_q[i] <= '0;
      else if (ack[i] && (cnt_q[i] != {STAT_W{1'b1}})) cnt_q[i] <= cnt_q[i] + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign gnt_cnt[g*STAT_W +: STAT_W] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random traffic vs a rule-level model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*DW-1:0] req_data;
  logic          fifo_full;
  logic          stats_clr;
  logic [N-1:0]  ack, ack1;
  logic          fifo_wr, fifo_wr1;
  logic [DW-1:0] fifo_data, fifo_data1;
  logic [1:0]    owner, owner1;
  logic          busy, busy1;
`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0] gnt_cnt, gnt_cnt1;
`endif

  int total = 0;
  int bad = 0;

  // Reference model: ownership, beats used, rotation start, per-requester ack counts.
  bit  m_own;
  int  m_owner, m_beats, m_ptr;
  int  m_cnt [N];

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .fifo_wr(fifo_wr), .fifo_data(fifo_data), .fifo_full(fifo_full),
    .owner(owner), .busy(busy)
`ifdef FIFO_ARB_STATS_EN
    , .stats_clr(stats_clr), .gnt_cnt(gnt_cnt)
`endif
  );

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack1),
    .fifo_wr(fifo_wr1), .fifo_data(fifo_data1), .fifo_full(fifo_full),
    .owner(owner1), .busy(busy1)
`ifdef FIFO_ARB_STATS_EN
    , .stats_clr(stats_clr), .gnt_cnt(gnt_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] onehot(input int e);
    return (e < 0) ? 32'd0 : (32'd1 << e);
  endfunction

  function automatic int model_winner(input logic [N-1:0] rq);
    int j;
    if (m_own && rq[m_owner] && m_beats < MB) return m_owner;
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (rq[j]) return j;
    end
    return -1;
  endfunction

  // One clock: drive, check at the falling edge, advance the model at the rising edge.
  // e0/e1: directed expected winner for dut/dut1 (-1 = no ack, -2 = not checked).
  task automatic step(input logic r, input logic [N-1:0] rq, input logic f,
                      input logic clr, input int e0, input int e1);
    int ew;
    rst = r; req = rq; fifo_full = f; stats_clr = clr;
    req_data = $urandom;
    @(negedge clk);
    ew = (r || f) ? -1 : model_winner(rq);
    check("ack", 32'(ack), onehot(ew));
    check("fifo_wr", 32'(fifo_wr), (ew >= 0) ? 32'd1 : 32'd0);
    if (ew >= 0) check("fifo_data", 32'(fifo_data), 32'(req_data[ew*DW +: DW]));
    check("owner", 32'(owner), 32'(m_owner));
    check("busy", 32'(busy), 32'(m_own));
    if (e0 != -2) check("dir_ack", 32'(ack), onehot(e0));
    if (e1 != -2) check("mb1_ack", 32'(ack1), onehot(e1));
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < N; i++) check("gnt_cnt", 32'(gnt_cnt[i*16 +: 16]), 32'(m_cnt[i]));
`endif
    @(posedge clk);
    if (r) begin
      m_own = 0; m_owner = 0; m_beats = 0; m_ptr = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      if (ew >= 0) begin
        if (m_own && ew == m_owner && m_beats < MB) m_beats++;
        else begin
          m_own = 1; m_owner = ew; m_beats = 1; m_ptr = (ew + 1) % N;
        end
        if (m_cnt[ew] != 65535) m_cnt[ew]++;
      end else if (!f && m_own) begin
        m_own = 0; m_owner = 0; m_beats = 0;
      end
      if (clr) for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end
    #1;
  endtask

  initial begin
    logic [N-1:0] rq;
    int full_seq [8];
    int drop_seq [6];
    m_own = 0; m_owner = 0; m_beats = 0; m_ptr = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    rst = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0; stats_clr = 1'b0;

    // Reset with requests present: no acks.
    step(1, 4'b1111, 0, 0, -1, -1);
    step(1, 4'b1111, 0, 0, -1, -1);

    // Two requesters share bursts of four: 0,0,0,0,2,2,2,2,...
    for (int k = 0; k < 24; k++) step(0, 4'b0101, 0, 0, ((k / 4) % 2) * 2, -2);

    // Per-beat round robin on the MAX_BURST=1 instance.
    step(1, 4'b0000, 0, 0, -1, -1);
    for (int k = 0; k < 16; k++) step(0, 4'b1111, 0, 0, -2, k % 4);

    // Full stall in the middle of a burst keeps ownership.
    full_seq = '{0, 0, -1, -1, -1, 0, 0, 1};
    step(1, 4'b0000, 0, 0, -1, -2);
    for (int k = 0; k < 8; k++) step(0, 4'b0011, (k >= 2 && k <= 4), 0, full_seq[k], -2);

    // Owner withdraws mid-burst; requester 3 takes over in the same cycle.
    drop_seq = '{0, 0, 3, 3, 3, 3};
    step(1, 4'b0000, 0, 0, -1, -2);
    for (int k = 0; k < 6; k++) step(0, (k < 2) ? 4'b1001 : 4'b1000, 0, 0, drop_seq[k], -2);
    step(0, 4'b1001, 0, 0, 0, -2);

    // Sole requester is acked every cycle across burst boundaries.
    for (int k = 0; k < 10; k++) step(0, 4'b0010, 0, 0, 1, -2);
    step(0, 4'b0000, 0, 0, -1, -2);

    // Counter clear racing an ack, then reset mid-burst.
    step(1, 4'b0000, 0, 0, -1, -2);
    for (int k = 0; k < 5; k++) step(0, 4'b0100, 0, 0, 2, -2);
    step(0, 4'b0100, 0, 1, 2, -2);
    step(0, 4'b0100, 0, 0, 2, -2);
    step(1, 4'b0100, 0, 0, -1, -1);
    step(0, 4'b0000, 0, 0, -1, -1);

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      rq = 4'($urandom);
      step(($urandom_range(63) == 0), rq, ($urandom_range(4) == 0),
           ($urandom_range(31) == 0), -2, -2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
